// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: turns MIPS load/store requests into word-aligned
// bus transactions with byte enables, extends load data and reports AdEL/AdES/timeouts.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        adel_o,
    output logic        ades_o,
    output logic        bus_err_o,
    output logic [31:0] bad_vaddr_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } state_e;

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] w;
        case (size)
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_ext(input logic [1:0] size, input logic [1:0] lane,
                                             input logic uns, input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = d[{lane, 3'b000} +: 8];
        h = lane[1] ? d[31:16] : d[15:0];
        case (size)
            2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'h0000, h}   : {{16{h[15]}}, h};
            default: r = d;
        endcase
        return r;
    endfunction

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic          wr_q, wr_d;
    logic          bus_req_q, bus_req_d;
    logic          bus_we_q, bus_we_d;
    logic [3:0]    bus_be_q, bus_be_d;
    logic [31:0]   bus_wdata_q, bus_wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   bad_vaddr_q, bad_vaddr_d;
    logic          done_q, done_d;
    logic          bus_err_q, bus_err_d;
    logic          adel_q, adel_d;
    logic          ades_q, ades_d;
    logic          stall_s;
    logic          req_s;
    logic          misaligned_s;

    assign req_s        = mem_read_i | mem_write_i;
    assign misaligned_s = ((mem_size_i == 2'b01) && addr_i[0]) ||
                          (mem_size_i[1] && (addr_i[1:0] != 2'b00));

    // Next-state and next-output logic for the access FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        size_d      = size_q;
        uns_d       = uns_q;
        wr_d        = wr_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        bad_vaddr_d = bad_vaddr_q;
        done_d      = 1'b0;
        bus_err_d   = 1'b0;
        adel_d      = 1'b0;
        ades_d      = 1'b0;
        stall_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    stall_s = 1'b1;
                    addr_d  = addr_i;
                    size_d  = mem_size_i;
                    uns_d   = mem_unsigned_i;
                    wr_d    = mem_write_i;
                    if (misaligned_s) begin
                        state_d     = ST_ERR;
                        adel_d      = ~mem_write_i;
                        ades_d      = mem_write_i;
                        bad_vaddr_d = addr_i;
                    end else begin
                        state_d     = ST_BUS;
                        cnt_d       = '0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_write_i;
                        bus_be_d    = lane_be(mem_size_i, addr_i[1:0]);
                        bus_wdata_d = lane_wdata(mem_size_i, wdata_i);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                stall_s = 1'b1;
                if (bus_ack_i) begin
                    state_d   = ST_DONE;
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    done_d    = 1'b1;
                    if (!wr_q) begin
                        rdata_d = load_ext(size_q, addr_q[1:0], uns_q, bus_rdata_i);
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_DONE;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    done_d      = 1'b1;
                    bus_err_d   = 1'b1;
                    rdata_d     = 32'h0000_0000;
                    bad_vaddr_d = addr_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // The pipeline advances at the end of DONE/ERR, so both return straight to IDLE.
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered-output update with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= 32'h0000_0000;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            wr_q        <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'h0000_0000;
            rdata_q     <= 32'h0000_0000;
            bad_vaddr_q <= 32'h0000_0000;
            done_q      <= 1'b0;
            bus_err_q   <= 1'b0;
            adel_q      <= 1'b0;
            ades_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            wr_q        <= wr_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            bad_vaddr_q <= bad_vaddr_d;
            done_q      <= done_d;
            bus_err_q   <= bus_err_d;
            adel_q      <= adel_d;
            ades_q      <= ades_d;
        end
    end

    assign stall_o     = stall_s;
    assign done_o      = done_q;
    assign rdata_o     = rdata_q;
    assign adel_o      = adel_q;
    assign ades_o      = ades_q;
    assign bus_err_o   = bus_err_q;
    assign bad_vaddr_o = bad_vaddr_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = {addr_q[31:2], 2'b00};
    assign bus_be_o    = bus_be_q;
    assign bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: aligned loads/stores, wait states, address errors,
// bus timeout (TIMEOUT=4) and reset in the middle of a bus transaction.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write, mem_unsigned;
    logic [1:0]  mem_size;
    logic [31:0] addr, wdata;
    logic        stall, done, adel, ades, bus_err, bus_req, bus_we;
    logic [31:0] rdata, bad_vaddr, bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        bus_ack;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_read_i     (mem_read),
        .mem_write_i    (mem_write),
        .mem_size_i     (mem_size),
        .mem_unsigned_i (mem_unsigned),
        .addr_i         (addr),
        .wdata_i        (wdata),
        .stall_o        (stall),
        .done_o         (done),
        .rdata_o        (rdata),
        .adel_o         (adel),
        .ades_o         (ades),
        .bus_err_o      (bus_err),
        .bad_vaddr_o    (bad_vaddr),
        .bus_req_o      (bus_req),
        .bus_we_o       (bus_we),
        .bus_addr_o     (bus_addr),
        .bus_be_o       (bus_be),
        .bus_wdata_o    (bus_wdata),
        .bus_ack_i      (bus_ack),
        .bus_rdata_i    (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] brd,
                          input int waits, input logic [3:0] ebe, input logic [31:0] ewd,
                          input logic [31:0] erd);
        tick();
        mem_read = ~wr; mem_write = wr; mem_size = sz; mem_unsigned = uns; addr = a; wdata = wd;
        #1;
        chk({tag, " req-cycle stall"}, {31'd0, stall}, 32'd1);
        chk({tag, " req-cycle bus_req"}, {31'd0, bus_req}, 32'd0);
        chk({tag, " req-cycle done"}, {31'd0, done}, 32'd0);
        for (int k = 1; k <= waits + 1; k++) begin
            tick();
            if (k == 1) begin
                mem_read = 1'b0; mem_write = 1'b0; wdata = 32'h0; addr = 32'hFFFF_FFFF;
            end
            bus_ack = (k == waits + 1);
            bus_rdata = brd;
            #1;
            chk({tag, " bus_req"}, {31'd0, bus_req}, 32'd1);
            chk({tag, " bus_addr"}, bus_addr, {a[31:2], 2'b00});
            chk({tag, " bus_be"}, {28'd0, bus_be}, {28'd0, ebe});
            chk({tag, " bus_wdata"}, bus_wdata, ewd);
            chk({tag, " bus_we"}, {31'd0, bus_we}, {31'd0, wr});
            chk({tag, " bus stall"}, {31'd0, stall}, 32'd1);
            chk({tag, " bus done"}, {31'd0, done}, 32'd0);
        end
        tick();
        bus_ack = 1'b0;
        bus_rdata = 32'h0;
        #1;
        chk({tag, " done"}, {31'd0, done}, 32'd1);
        chk({tag, " done stall"}, {31'd0, stall}, 32'd0);
        chk({tag, " done bus_req"}, {31'd0, bus_req}, 32'd0);
        chk({tag, " done bus_err"}, {31'd0, bus_err}, 32'd0);
        if (!wr) chk({tag, " rdata"}, rdata, erd);
    endtask

    task automatic misaligned(input string tag, input logic wr, input logic [1:0] sz,
                              input logic [31:0] a);
        tick();
        mem_read = ~wr; mem_write = wr; mem_size = sz; mem_unsigned = 1'b0; addr = a;
        wdata = 32'h1234_5678;
        #1;
        chk({tag, " req stall"}, {31'd0, stall}, 32'd1);
        tick();
        mem_read = 1'b0; mem_write = 1'b0;
        #1;
        chk({tag, " adel"}, {31'd0, adel}, {31'd0, ~wr});
        chk({tag, " ades"}, {31'd0, ades}, {31'd0, wr});
        chk({tag, " bad_vaddr"}, bad_vaddr, a);
        chk({tag, " bus_req"}, {31'd0, bus_req}, 32'd0);
        chk({tag, " stall"}, {31'd0, stall}, 32'd0);
        chk({tag, " done"}, {31'd0, done}, 32'd0);
        tick();
        #1;
        chk({tag, " pulse adel"}, {31'd0, adel}, 32'd0);
        chk({tag, " pulse ades"}, {31'd0, ades}, 32'd0);
        chk({tag, " after bus_req"}, {31'd0, bus_req}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'b00; mem_unsigned = 1'b0;
        addr = 32'h0; wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
        #3;
        chk("rst stall", {31'd0, stall}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst bus_we", {31'd0, bus_we}, 32'd0);
        chk("rst adel/ades/err", {29'd0, adel, ades, bus_err}, 32'd0);
        chk("rst rdata", rdata, 32'h0);
        chk("rst bad_vaddr", bad_vaddr, 32'h0);
        chk("rst bus_addr", bus_addr, 32'h0);
        chk("rst bus_be", {28'd0, bus_be}, 32'd0);
        chk("rst bus_wdata", bus_wdata, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;

        access("LW 0x100", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0,
               4'b1111, 32'h0, 32'hDEAD_BEEF);
        access("LB 0x103", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h8012_3456, 0,
               4'b1000, 32'h0, 32'hFFFF_FF80);
        access("LBU 0x103", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h8012_3456, 0,
               4'b1000, 32'h0, 32'h0000_0080);
        access("LH 0x102", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h8012_3456, 1,
               4'b1100, 32'h0, 32'hFFFF_8012);
        access("LHU 0x100", 1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 32'h8012_F456, 0,
               4'b0011, 32'h0, 32'h0000_F456);
        access("SB 0x101", 1'b1, 2'b00, 1'b0, 32'h101, 32'hFFFF_FF5A, 32'h0, 0,
               4'b0010, 32'h5A5A_5A5A, 32'h0);
        access("SH 0x202", 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_ABCD, 32'h0, 3,
               4'b1100, 32'hABCD_ABCD, 32'h0);
        // A store must leave the previous load's rdata untouched.
        chk("SH rdata hold", rdata, 32'h0000_F456);
        access("SW 0x300", 1'b1, 2'b10, 1'b0, 32'h300, 32'h1357_9BDF, 32'h0, 0,
               4'b1111, 32'h1357_9BDF, 32'h0);

        misaligned("LW 0x101", 1'b0, 2'b10, 32'h101);
        misaligned("SW 0x106", 1'b1, 2'b10, 32'h106);
        misaligned("LH 0x203", 1'b0, 2'b01, 32'h203);

        // Timeout: ack never arrives, bus_req holds for TIMEOUT=4 cycles.
        tick();
        mem_read = 1'b1; mem_size = 2'b10; mem_unsigned = 1'b0; addr = 32'h400;
        #1;
        chk("TO req stall", {31'd0, stall}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            mem_read = 1'b0;
            #1;
            chk("TO bus_req", {31'd0, bus_req}, 32'd1);
            chk("TO done early", {31'd0, done}, 32'd0);
        end
        tick();
        #1;
        chk("TO done", {31'd0, done}, 32'd1);
        chk("TO bus_err", {31'd0, bus_err}, 32'd1);
        chk("TO rdata", rdata, 32'h0);
        chk("TO bad_vaddr", bad_vaddr, 32'h400);
        chk("TO bus_req", {31'd0, bus_req}, 32'd0);
        chk("TO stall", {31'd0, stall}, 32'd0);
        tick();
        #1;
        chk("TO pulse done", {31'd0, done}, 32'd0);
        chk("TO pulse bus_err", {31'd0, bus_err}, 32'd0);

        // Reset asserted during BUS abandons the access immediately.
        tick();
        mem_read = 1'b1; mem_size = 2'b10; addr = 32'h500;
        tick();
        mem_read = 1'b0;
        #1;
        chk("RST mid bus_req before", {31'd0, bus_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("RST mid bus_req", {31'd0, bus_req}, 32'd0);
        chk("RST mid stall", {31'd0, stall}, 32'd0);
        chk("RST mid done", {31'd0, done}, 32'd0);
        tick();
        rst_n = 1'b1;
        access("LW after rst", 1'b0, 2'b10, 1'b0, 32'h504, 32'h0, 32'h1234_5678, 0,
               4'b1111, 32'h0, 32'h1234_5678);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
